// File: rtl/btn_conditioner_pkg.sv
// Shared types and defaults for the button/switch conditioning slice.
// Debounce state encoding and the default debounce interval live here.
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_WAIT_LO = 2'd3
    } deb_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned CNT_W_DEF           = 20;

    // Debounced level as seen by the capture logic: high once a press is accepted
    // and until the matching release is accepted.
    function automatic logic state_is_high(input deb_state_t st);
        return (st == S_HIGH) || (st == S_WAIT_LO);
    endfunction

endpackage

// File: rtl/btn_conditioner_debounce_fsm.sv
// One button channel: 2-FF synchroniser, debounce timer/FSM and registered pulses.
//
//   state     | meaning
//   S_LOW     | accepted level 0, input stable low
//   S_WAIT_HI | input went high, timing the stable interval
//   S_HIGH    | accepted level 1, input stable high
//   S_WAIT_LO | input went low, timing the stable interval
module debounce_fsm
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic press,
    output logic rel
);

    // Down-counter reloaded on entry to a wait state; terminal count is zero.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    deb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt, rel_nxt, level_nxt;

    assign s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            state  <= S_LOW;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
            rel    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            level  <= level_nxt;
            press  <= press_nxt;
            rel    <= rel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        unique case (state)
            S_LOW: begin
                if (s) begin
                    state_nxt = S_WAIT_HI;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            S_WAIT_HI: begin
                if (!s) begin
                    state_nxt = S_LOW;
                end else if (cnt == '0) begin
                    state_nxt = S_HIGH;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_nxt = S_WAIT_LO;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            S_WAIT_LO: begin
                if (s) begin
                    state_nxt = S_HIGH;
                end else if (cnt == '0) begin
                    state_nxt = S_LOW;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = S_LOW;
        endcase
        level_nxt = state_is_high(state_nxt);
    end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions raw push-buttons (sync + debounce + press/release pulses) and
// synchronises the slide switches for the operand-capture stage.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned SW_W            = 8,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [SW_W-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [SW_W-1:0]  sw_sync
);

    logic [SW_W-1:0] sw_meta;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (btn_raw[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rel   (btn_release[i])
        );
    end

    // Switches are only synchronised; the consumer samples them on btn_press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_raw;
            sw_sync <= sw_meta;
        end
    end

endmodule
